// File: rtl/cache_pkg.sv
// Shared cache geometry defaults and the storage bank address-width ceiling.
package cache_pkg;
   localparam int CACHE_DATA_WIDTH    = 32;
   localparam int CACHE_INDEX_WIDTH   = 6;
   localparam int MAX_BANK_ADDR_WIDTH = 16;
endpackage

// File: rtl/cache_data_bank.sv
// Simple dual-port cache storage bank: one write port, one synchronous read port (1-cycle latency).
// Read-first on same-address collision; define CACHE_BANK_BYPASS_EN for write-first forwarding.
module cache_data_bank
   import cache_pkg::*;
#(
   parameter int DATA_WIDTH = CACHE_DATA_WIDTH,
   parameter int ADDR_WIDTH = CACHE_INDEX_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_we,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   generate
      if ((DATA_WIDTH < 1) || (ADDR_WIDTH < 1) || (ADDR_WIDTH > MAX_BANK_ADDR_WIDTH)) begin : g_bad_param
         INVALID_CACHE_BANK_PARAM u_invalid ();
      end
   endgenerate

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Storage has no reset so it maps onto an SRAM macro.
   always_ff @(posedge clk) begin
      if (i_we && !rst) begin
         mem[i_waddr] <= i_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= mem[i_raddr];
      end
   end

`ifdef CACHE_BANK_BYPASS_EN
   logic                  bypass_q;
   logic [DATA_WIDTH-1:0] bypass_dat_q;

   // A same-index write at the read edge overrides the stale array read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bypass_q     <= 1'b0;
         bypass_dat_q <= '0;
      end else begin
         bypass_q     <= i_we && (i_waddr == i_raddr);
         bypass_dat_q <= i_wdata;
      end
   end

   assign o_rdata = bypass_q ? bypass_dat_q : rdata_q;
`else
   assign o_rdata = rdata_q;
`endif

endmodule

// File: tb/tb_cache_data_bank.sv
// Directed bench for cache_data_bank: a 32-bit data bank and a 20-bit tag bank sharing clock and reset.
module tb_cache_data_bank;

   logic        clk;
   logic        rst;
   logic        we;
   logic [31:0] wdata;
   logic [5:0]  waddr;
   logic [5:0]  raddr;
   logic [31:0] rdata;

   logic        t_we;
   logic [19:0] t_wdata;
   logic [5:0]  t_waddr;
   logic [5:0]  t_raddr;
   logic [19:0] t_rdata;

   int vectors;
   int miscompares;

   cache_data_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .i_we    (we),
      .i_wdata (wdata),
      .i_waddr (waddr),
      .i_raddr (raddr),
      .o_rdata (rdata)
   );

   cache_data_bank #(.DATA_WIDTH(20), .ADDR_WIDTH(6)) u_tag (
      .clk     (clk),
      .rst     (rst),
      .i_we    (t_we),
      .i_wdata (t_wdata),
      .i_waddr (t_waddr),
      .i_raddr (t_raddr),
      .o_rdata (t_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] exp);
      vectors++;
      assert (rdata === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, rdata, exp);
      end
   endtask

   task automatic chk_tag(input string tag, input logic [19:0] exp);
      vectors++;
      assert (t_rdata === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, t_rdata, exp);
      end
   endtask

   task automatic wr(input logic [5:0] a, input logic [31:0] d);
      we    = 1'b1;
      waddr = a;
      wdata = d;
      tick();
      we    = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst     = 1'b1;
      we      = 1'b0;
      wdata   = '0;
      waddr   = '0;
      raddr   = '0;
      t_we    = 1'b0;
      t_wdata = '0;
      t_waddr = '0;
      t_raddr = '0;

      tick();
      tick();
      chk("reset_rdata", 32'h0);
      chk_tag("reset_tag_rdata", 20'h0);
      rst = 1'b0;

      // Boundary indices 0 and 63 must not alias.
      wr(6'd0, 32'h1111_0000);
      wr(6'd63, 32'h6363_6363);
      chk("addr0_during_write63", 32'h1111_0000);
      raddr = 6'd63;
      tick();
      chk("addr63_read", 32'h6363_6363);
      raddr = 6'd0;
      tick();
      chk("addr0_read", 32'h1111_0000);

      wr(6'd5, 32'hDEAD_BEEF);
      raddr = 6'd5;
      #2;
      chk("latency_hold", 32'h1111_0000);
      tick();
      chk("basic_read", 32'hDEAD_BEEF);

      wr(6'd0, 32'h0000_0000);
      wr(6'd1, 32'h0000_0011);
      wr(6'd2, 32'h0000_0022);
      raddr = 6'd0;
      tick();
      chk("b2b_0", 32'h0000_0000);
      raddr = 6'd1;
      tick();
      chk("b2b_1", 32'h0000_0011);
      raddr = 6'd2;
      tick();
      chk("b2b_2", 32'h0000_0022);

      wr(6'd3, 32'hAAAA_AAAA);
      we    = 1'b1;
      waddr = 6'd3;
      wdata = 32'h5555_5555;
      raddr = 6'd3;
      tick();
      we = 1'b0;
`ifdef CACHE_BANK_BYPASS_EN
      chk("same_addr_collision", 32'h5555_5555);
`else
      chk("same_addr_collision", 32'hAAAA_AAAA);
`endif
      tick();
      chk("same_addr_next_read", 32'h5555_5555);

      wr(6'd8, 32'h0000_9876);
      we    = 1'b1;
      waddr = 6'd7;
      wdata = 32'h0000_1234;
      raddr = 6'd8;
      tick();
      we = 1'b0;
      chk("diff_addr_collision", 32'h0000_9876);
      raddr = 6'd7;
      tick();
      chk("diff_addr_written", 32'h0000_1234);

      wr(6'd9, 32'h0000_CAFE);
      raddr = 6'd9;
      tick();
      chk("pre_reset_read", 32'h0000_CAFE);
      #2;
      rst = 1'b1;
      #1;
      chk("async_reset_clear", 32'h0);
      we    = 1'b1;
      waddr = 6'd5;
      wdata = 32'hFFFF_FFFF;
      raddr = 6'd5;
      tick();
      tick();
      chk("reset_hold", 32'h0);
      we  = 1'b0;
      rst = 1'b0;
      tick();
      chk("post_reset_mem_kept", 32'hDEAD_BEEF);

      // 20-bit tag configuration, including the top bit.
      t_we    = 1'b1;
      t_waddr = 6'd10;
      t_wdata = 20'hABCDE;
      tick();
      t_waddr = 6'd11;
      t_wdata = 20'hFFFFF;
      tick();
      t_we    = 1'b0;
      t_raddr = 6'd10;
      tick();
      chk_tag("tag_read_10", 20'hABCDE);
      t_raddr = 6'd11;
      tick();
      chk_tag("tag_read_11", 20'hFFFFF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cache_data_bank.md
Name: cache_data_bank

Overview:
- Simple dual-port storage bank used as the building block of cache data and tag arrays.
- One write port and one read port, both addressed by the cache index.
- Read is synchronous: the read address is sampled on the clock edge and data appears after it.
- The instruction cache presents the next-cycle index, so the data is valid during the current-PC cycle.
- One instance per data word of a line, plus one for tags.

Parameters:
- DATA_WIDTH, 32, bit width of each entry; legal range ≥1.
- ADDR_WIDTH, 6, address bit width; legal range 1..16. Bank depth is 2^ADDR_WIDTH entries.

Ports:
- clk  in  1  clock; all sampling on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- i_we  in  1  write enable.
- i_wdata  in  DATA_WIDTH  write data.
- i_waddr  in  ADDR_WIDTH  write address.
- i_raddr  in  ADDR_WIDTH  read address, sampled at the clock edge.
- o_rdata  out  DATA_WIDTH  read data for the address sampled at the previous edge.

Behaviour:
- Storage: array mem[0 .. 2^ADDR_WIDTH-1] of DATA_WIDTH bits.
  - Contents are not reset (maps to SRAM).
  - Contents are X in simulation until written.
- Write: at a rising edge with i_we=1 and rst=0, mem[i_waddr] <= i_wdata. Writes complete in one cycle.
- Read latency is exactly one cycle.
  - At a rising edge with rst=0, the bank registers the read of i_raddr.
  - o_rdata then shows mem[sampled i_raddr] until the next edge.
  - o_rdata is driven from a register or registered address only; there is no combinational path from i_raddr to o_rdata.
- Read every cycle: there is no read enable.
- Read-during-write to the same address in the same edge is read-first: o_rdata returns the old contents. The new value is visible on the next read.
- Different addresses in the same cycle: the read and write are fully independent.
- Reset:
  - rst asserted forces o_rdata to 0 immediately (asynchronous) and holds it at 0 while rst=1.
  - No writes are performed while rst=1.
  - The first edge after rst deasserts samples i_raddr normally.
  - Reset asserted mid-operation discards any pending read result. mem is retained.
- Address wrap: addresses are ADDR_WIDTH bits wide, so there is no out-of-range access.
- Parameter check: if DATA_WIDTH<1 or ADDR_WIDTH<1 or ADDR_WIDTH>16, elaboration fails. This is done by instantiating the undefined module INVALID_CACHE_BANK_PARAM inside a generate-if.
- There is no handshake: a write is accepted every cycle and a read is produced every cycle.

Optional Feature:
- Macro name: CACHE_BANK_BYPASS_EN.
- When defined:
  - Read-during-write to the same address is write-first: o_rdata in the following cycle equals i_wdata written at that edge.
  - Implement this by registering a bypass flag (i_we && i_waddr==i_raddr) and the write data, then muxing on the output.
  - The reset clears the bypass flag.
- When undefined: read-first behaviour as above, with no bypass logic.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package cache_pkg holds:
  - default widths CACHE_DATA_WIDTH=32 and CACHE_INDEX_WIDTH=6;
  - MAX_BANK_ADDR_WIDTH=16.
- The bank itself is a single module and needs no sub-module.
- The bypass path is inline logic under the macro.
- The cache top instantiates LINE_SIZE data banks plus one tag bank of this module.

Test Plan:
- Basic write/read: write 0xDEADBEEF at addr 5, then set i_raddr=5 → o_rdata=0xDEADBEEF exactly one edge after the address is sampled.
- Back-to-back reads: i_raddr steps 0,1,2 on consecutive edges after filling mem[n]=n*0x11 → o_rdata sequence 0x00, 0x11, 0x22 with a one-cycle lag.
- Same-address collision: mem[3]=0xAAAA_AAAA, then write 0x5555_5555 to addr 3 while reading addr 3.
  - Without macro: o_rdata=0xAAAAAAAA, then 0x55555555 on the next read.
  - With CACHE_BANK_BYPASS_EN: 0x55555555 immediately.
- Different-address collision: write 0x1234 to addr 7 while reading addr 8 (holding 0x9876) → o_rdata=0x9876, and mem[7]=0x1234 is readable afterwards.
- Async reset: assert rst mid-cycle while o_rdata=0xCAFE.
  - o_rdata=0 before the next edge.
  - i_we=1 during reset leaves the target entry unchanged.
  - After release, a read of addr 5 still returns 0xDEADBEEF.
- Boundary: ADDR_WIDTH=6, write/read addr 63 and addr 0 with distinct data → no aliasing. DATA_WIDTH=20 tag configuration returns a 20-bit value intact.
